hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Issue controller for the RV32 decode stage.
- Keeps a register scoreboard of long-latency destinations (load, MUL/DIV, AMO) and stalls decode on RAW/WAW hazards or when the outstanding-op limit is reached.
- Sequences pipeline flushes on control redirects from execute.
- Drives decode's stall input and its 2-bit control-hazard flush vector.

Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- MAX_OUTSTANDING, 4, max simultaneously pending long-latency writes (1..NUM_REGS-1).
- FLUSH_CYCLES, 2, cycles the FLUSH state holds after a redirect (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  decode holds a valid instruction
- id_rs1_i  in  5  source register 1
- id_rs2_i  in  5  source register 2
- id_rs1_used_i  in  1  instruction reads rs1
- id_rs2_used_i  in  1  instruction reads rs2
- id_rd_i  in  5  destination register
- id_rd_wr_i  in  1  instruction writes rd
- id_long_lat_i  in  1  result returns via writeback port (load/M/A)
- wb_valid_i  in  1  long-latency writeback this cycle
- wb_rd_i  in  5  writeback destination
- redirect_i  in  1  execute resolved taken branch/jump/trap
- issue_o  out  1  instruction leaves decode this cycle
- hazard_stall_o  out  1  hold decode/fetch
- control_hazard_o  out  2  bit0 flush IF/ID, bit1 flush ID/EX
- pending_o  out  NUM_REGS  scoreboard, bit0 always 0
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  pending count
- wb_err_o  out  1  1-cycle pulse: writeback to a non-pending register

Behaviour:
- Reset: all outputs 0, scoreboard cleared, count 0, FSM to RUN. Asynchronous assertion applies mid-operation and drops all in-flight tracking.
- FSM RUN:
  - redirect_i -> FLUSH, counter loaded with FLUSH_CYCLES-1.
  - control_hazard_o = 2'b11 in the redirect cycle.
- FSM FLUSH:
  - control_hazard_o = 2'b01; issue_o = 0; hazard_stall_o = 0.
  - Counter decrements each cycle; at 0 -> RUN.
  - redirect_i while in FLUSH reloads the counter and drives 2'b11 that cycle.
- Hazard (RUN only), any of:
  - (rs1_used & rs1!=0 & pend[rs1])
  - (rs2_used & rs2!=0 & pend[rs2])
  - (rd_wr & rd!=0 & pend[rd]) (WAW)
  - (long_lat & rd_wr & rd!=0 & count==MAX_OUTSTANDING)
- hazard_stall_o = id_valid_i & hazard & RUN, combinational.
- issue_o = id_valid_i & ~hazard & RUN & ~redirect_i.
- Scoreboard set: on issue_o & id_long_lat_i & id_rd_wr_i & id_rd_i!=0, set pend[rd] and increment count at the next edge.
- Scoreboard clear: on wb_valid_i & wb_rd_i!=0 & pend[wb_rd_i], clear the bit and decrement count.
  - wb_valid_i to a non-pending register or x0: no state change; wb_err_o pulses the next cycle.
- Simultaneous set and clear:
  - Different registers: both apply; count unchanged.
  - Same register: only reachable with the bypass feature (otherwise blocked by WAW); result is the bit set and count unchanged.
- Writebacks are processed in every state, including FLUSH. A flush never clears the scoreboard, because flushed ops are younger than pending ones.
- Count never exceeds MAX_OUTSTANDING and never underflows.

Optional Feature:
- WB_BYPASS_EN defined:
  - Hazard lookup uses pend & ~(wb_valid_i ? onehot(wb_rd_i) : 0), so a same-cycle writeback resolves the hazard with no stall.
  - The count check also credits the same-cycle clear.
- WB_BYPASS_EN undefined:
  - Lookup uses the registered scoreboard only.
  - A dependent instruction stalls through the writeback cycle and issues the cycle after.

Test Plan:
- Issue load rd=5, then add rs1=5 the next cycle, wb rd=5 three cycles later. Required: stall_o=1 for 3 cycles and issue the cycle after wb (bypass off), or issue in the wb cycle (bypass on). pending_o[5] rises 1 cycle after load issue and falls 1 cycle after wb.
- Issue 4 loads to x1..x4 back-to-back, then a 5th load to x6. Required: outstanding_o=4 and stall_o=1 on the 5th until any wb, then it issues. Count returns to 0 after all writebacks.
- Load rd=0, and an instruction with rs1=0 while x0 activity is present. Required: pending_o stays 0, no stall, no count change.
- redirect_i pulse in RUN with FLUSH_CYCLES=2. Required: control_hazard_o sequence 11,01,01,00 and issue_o=0 for 3 cycles. A second redirect during FLUSH gives 11 then two more 01 cycles.
- wb_valid_i with wb_rd_i=9, not pending. Required: wb_err_o=1 for exactly one cycle, scoreboard and count unchanged.
- Assert rst_i with 3 ops pending and in FLUSH. Required: all outputs 0 immediately. After deassert: RUN, pending_o=0, outstanding_o=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl -- RV32 decode-stage issue controller.
//
// Tracks long-latency destinations (load, MUL/DIV, AMO) in a register
// scoreboard and stalls decode on RAW/WAW hazards or when the number of
// outstanding long-latency writes reaches MAX_OUTSTANDING. It also sequences
// the IF/ID and ID/EX flushes that follow a control redirect from execute.
//
// Optional build macro: WB_BYPASS_EN
//   defined   : a writeback in the same cycle resolves a hazard on that
//               register and frees a slot for the count check (no stall).
//   undefined : hazard lookup uses only the registered scoreboard.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_valid_i              decode holds a valid instruction
//   id_rs1_i/id_rs2_i       source registers, with *_used_i qualifiers
//   id_rd_i, id_rd_wr_i     destination register and write enable
//   id_long_lat_i           result returns via the writeback port
//   wb_valid_i, wb_rd_i     long-latency writeback and its destination
//   redirect_i              execute resolved a taken branch/jump/trap
//   issue_o                 instruction leaves decode this cycle
//   hazard_stall_o          hold decode/fetch
//   control_hazard_o        bit0 flush IF/ID, bit1 flush ID/EX
//   pending_o               scoreboard (bit0 always 0)
//   outstanding_o           number of pending long-latency writes
//   wb_err_o                1-cycle pulse: writeback to a non-pending register
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  id_valid_i,
  input  logic [4:0]                            id_rs1_i,
  input  logic [4:0]                            id_rs2_i,
  input  logic                                  id_rs1_used_i,
  input  logic                                  id_rs2_used_i,
  input  logic [4:0]                            id_rd_i,
  input  logic                                  id_rd_wr_i,
  input  logic                                  id_long_lat_i,
  input  logic                                  wb_valid_i,
  input  logic [4:0]                            wb_rd_i,
  input  logic                                  redirect_i,
  output logic                                  issue_o,
  output logic                                  hazard_stall_o,
  output logic [1:0]                            control_hazard_o,
  output logic [NUM_REGS-1:0]                   pending_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  wb_err_o
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // One-hot decode of a register index; x0 never gets a bit, so every
  // lookup through this mask already excludes x0.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [4:0] idx);
    logic [NUM_REGS-1:0] v;
    v = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      v[i] = (idx == 5'(i));
    end
    return v;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FCW-1:0]      r_fcnt;
  logic [FCW-1:0]      w_fcnt_nxt;
  logic [1:0]          w_flush_vec;
  logic [NUM_REGS-1:0] r_pend;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic                r_wb_err;

  logic [NUM_REGS-1:0] w_rs1_oh, w_rs2_oh, w_rd_oh, w_wb_oh;
  logic [NUM_REGS-1:0] w_lookup, w_set_mask, w_clr_mask;
  logic [CW-1:0]       w_cnt_eff;
  logic                w_clr, w_set, w_hazard, w_run, w_issue, w_stall;

  assign w_rs1_oh = onehot(id_rs1_i);
  assign w_rs2_oh = onehot(id_rs2_i);
  assign w_rd_oh  = onehot(id_rd_i);
  assign w_wb_oh  = onehot(wb_rd_i);

  // Only a writeback to a currently pending register retires an entry.
  assign w_clr = wb_valid_i & (|(r_pend & w_wb_oh));

`ifdef WB_BYPASS_EN
  assign w_lookup  = r_pend & ~(wb_valid_i ? w_wb_oh : {NUM_REGS{1'b0}});
  assign w_cnt_eff = r_count - CW'(w_clr);
`else
  assign w_lookup  = r_pend;
  assign w_cnt_eff = r_count;
`endif

  assign w_hazard = (id_rs1_used_i & (|(w_lookup & w_rs1_oh)))
                  | (id_rs2_used_i & (|(w_lookup & w_rs2_oh)))
                  | (id_rd_wr_i    & (|(w_lookup & w_rd_oh)))
                  | (id_long_lat_i & id_rd_wr_i & (|w_rd_oh)
                     & (w_cnt_eff == CW'(MAX_OUTSTANDING)));

  assign w_run = (r_state == ST_RUN);

  // Combinational outputs are forced low while reset is asserted so that
  // every output reads 0 immediately, regardless of the decode inputs.
  assign w_issue = ~rst_i & id_valid_i & ~w_hazard & w_run & ~redirect_i;
  assign w_stall = ~rst_i & id_valid_i & w_hazard & w_run;

  assign w_set      = w_issue & id_long_lat_i & id_rd_wr_i & (|w_rd_oh);
  assign w_set_mask = w_set ? w_rd_oh : {NUM_REGS{1'b0}};
  assign w_clr_mask = w_clr ? w_wb_oh : {NUM_REGS{1'b0}};

  assign issue_o          = w_issue;
  assign hazard_stall_o   = w_stall;
  assign control_hazard_o = rst_i ? 2'b00 : w_flush_vec;
  assign pending_o        = r_pend;
  assign outstanding_o    = r_count;
  assign wb_err_o         = r_wb_err;

  // Flush sequencer next-state and flush-vector decode.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_flush_vec = 2'b00;
    case (r_state)
      ST_RUN: begin
        if (redirect_i) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
          w_flush_vec = 2'b11;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (redirect_i) begin
          w_fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
          w_flush_vec = 2'b11;
        end else if (r_fcnt == {FCW{1'b0}}) begin
          w_state_nxt = ST_RUN;
          w_flush_vec = 2'b01;
        end else begin
          w_fcnt_nxt  = r_fcnt - FCW'(1'b1);
          w_flush_vec = 2'b01;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = {FCW{1'b0}};
      end
    endcase
  end

  // Outstanding count: a set and a clear in the same cycle cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_set, w_clr})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // State, scoreboard and error-pulse registers. Clear is applied before
  // set so a same-register set/clear leaves the bit set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_fcnt   <= {FCW{1'b0}};
      r_pend   <= {NUM_REGS{1'b0}};
      r_count  <= {CW{1'b0}};
      r_wb_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_pend   <= (r_pend & ~w_clr_mask) | w_set_mask;
      r_count  <= w_count_nxt;
      r_wb_err <= wb_valid_i & ~w_clr;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_wr_i, id_long_lat_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
  logic        wb_valid_i, redirect_i;
  logic        issue_o, hazard_stall_o, wb_err_o;
  logic [1:0]  control_hazard_o;
  logic [31:0] pending_o;
  logic [2:0]  outstanding_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        iss;
    logic        stl;
    logic [1:0]  ch;
    logic [31:0] pend;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  hazard_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .id_rd_i          (id_rd_i),
    .id_rd_wr_i       (id_rd_wr_i),
    .id_long_lat_i    (id_long_lat_i),
    .wb_valid_i       (wb_valid_i),
    .wb_rd_i          (wb_rd_i),
    .redirect_i       (redirect_i),
    .issue_o          (issue_o),
    .hazard_stall_o   (hazard_stall_o),
    .control_hazard_o (control_hazard_o),
    .pending_o        (pending_o),
    .outstanding_o    (outstanding_o),
    .wb_err_o         (wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clr_in();
    id_valid_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    id_rd_i = 5'd0; id_rd_wr_i = 1'b0; id_long_lat_i = 1'b0;
    wb_valid_i = 1'b0; wb_rd_i = 5'd0; redirect_i = 1'b0;
  endtask

  task automatic set_ld(input logic [4:0] rd);
    id_valid_i = 1'b1; id_rd_i = rd; id_rd_wr_i = 1'b1; id_long_lat_i = 1'b1;
  endtask

  task automatic set_alu(input logic [4:0] rs1, input logic [4:0] rd);
    id_valid_i = 1'b1; id_rs1_i = rs1; id_rs1_used_i = 1'b1;
    id_rd_i = rd; id_rd_wr_i = 1'b1; id_long_lat_i = 1'b0;
  endtask

  task automatic set_wb(input logic [4:0] rd);
    wb_valid_i = 1'b1; wb_rd_i = rd;
  endtask

  task automatic cmp(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  // Push the expectation for the cycle just driven, compare it at the
  // falling edge, then move to 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic e_iss, input logic e_stl,
                      input logic [1:0] e_ch, input logic [31:0] e_pend,
                      input logic [2:0] e_cnt, input logic e_err);
    exp_t e;
    exp_q.push_back('{iss: e_iss, stl: e_stl, ch: e_ch, pend: e_pend,
                      cnt: e_cnt, err: e_err});
    @(negedge clk_i);
    e = exp_q.pop_front();
    cmp(tag, "issue",   32'(issue_o),          32'(e.iss));
    cmp(tag, "stall",   32'(hazard_stall_o),   32'(e.stl));
    cmp(tag, "ctrl",    32'(control_hazard_o), 32'(e.ch));
    cmp(tag, "pending", pending_o,             e.pend);
    cmp(tag, "count",   32'(outstanding_o),    32'(e.cnt));
    cmp(tag, "wb_err",  32'(wb_err_o),         32'(e.err));
    @(posedge clk_i);
    #1;
    clr_in();
  endtask

  initial begin
    rst_i = 1'b1;
    clr_in();
    @(posedge clk_i);
    #1;
    // Reset with busy inputs: everything must read 0.
    set_ld(5'd3); redirect_i = 1'b1; set_wb(5'd9);
    step("rst", 1'b0, 1'b0, 2'b00, 32'h0, 3'd0, 1'b0);
    rst_i = 1'b0;

    // Load x5, dependent add, writeback x5 three cycles after the load.
    set_ld(5'd5);             step("t1_ld",  1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
    set_alu(5'd5, 5'd10);     step("t1_s1",  1'b0, 1'b1, 2'b00, 32'h20, 3'd1, 1'b0);
    set_alu(5'd5, 5'd10);     step("t1_s2",  1'b0, 1'b1, 2'b00, 32'h20, 3'd1, 1'b0);
`ifdef WB_BYPASS_EN
    set_alu(5'd5, 5'd10); set_wb(5'd5);
                              step("t1_wb",  1'b1, 1'b0, 2'b00, 32'h20, 3'd1, 1'b0);
                              step("t1_aft", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
`else
    set_alu(5'd5, 5'd10); set_wb(5'd5);
                              step("t1_wb",  1'b0, 1'b1, 2'b00, 32'h20, 3'd1, 1'b0);
    set_alu(5'd5, 5'd10);     step("t1_iss", 1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
`endif

    // Four loads fill the outstanding limit; the fifth waits for a slot.
    set_ld(5'd1);             step("t2_l1",  1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
    set_ld(5'd2);             step("t2_l2",  1'b1, 1'b0, 2'b00, 32'h2,  3'd1, 1'b0);
    set_ld(5'd3);             step("t2_l3",  1'b1, 1'b0, 2'b00, 32'h6,  3'd2, 1'b0);
    set_ld(5'd4);             step("t2_l4",  1'b1, 1'b0, 2'b00, 32'hE,  3'd3, 1'b0);
    set_ld(5'd6);             step("t2_f1",  1'b0, 1'b1, 2'b00, 32'h1E, 3'd4, 1'b0);
    set_ld(5'd6);             step("t2_f2",  1'b0, 1'b1, 2'b00, 32'h1E, 3'd4, 1'b0);
`ifdef WB_BYPASS_EN
    set_ld(5'd6); set_wb(5'd2);
                              step("t2_wb",  1'b1, 1'b0, 2'b00, 32'h1E, 3'd4, 1'b0);
                              step("t2_idl", 1'b0, 1'b0, 2'b00, 32'h5A, 3'd4, 1'b0);
`else
    set_ld(5'd6); set_wb(5'd2);
                              step("t2_wb",  1'b0, 1'b1, 2'b00, 32'h1E, 3'd4, 1'b0);
    set_ld(5'd6);             step("t2_l6",  1'b1, 1'b0, 2'b00, 32'h1A, 3'd3, 1'b0);
`endif
    set_wb(5'd1);             step("t2_w1",  1'b0, 1'b0, 2'b00, 32'h5A, 3'd4, 1'b0);
    set_wb(5'd3);             step("t2_w3",  1'b0, 1'b0, 2'b00, 32'h58, 3'd3, 1'b0);
    set_wb(5'd4);             step("t2_w4",  1'b0, 1'b0, 2'b00, 32'h50, 3'd2, 1'b0);
    set_wb(5'd6);             step("t2_w6",  1'b0, 1'b0, 2'b00, 32'h40, 3'd1, 1'b0);
                              step("t2_end", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);

    // x0 is never tracked; a writeback to x0 is an error pulse.
    set_ld(5'd0);             step("t3_ld0", 1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
    set_alu(5'd0, 5'd0); set_wb(5'd0);
                              step("t3_rs0", 1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
                              step("t3_err", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b1);
                              step("t3_end", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);

    // Redirect in RUN: 11, 01, 01, 00 with no issue for three cycles.
    set_ld(5'd7); redirect_i = 1'b1;
                              step("t4_r",   1'b0, 1'b0, 2'b11, 32'h0,  3'd0, 1'b0);
    set_ld(5'd7);             step("t4_f1",  1'b0, 1'b0, 2'b01, 32'h0,  3'd0, 1'b0);
    set_ld(5'd7);             step("t4_f2",  1'b0, 1'b0, 2'b01, 32'h0,  3'd0, 1'b0);
    set_ld(5'd7);             step("t4_run", 1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
                              step("t4_p7",  1'b0, 1'b0, 2'b00, 32'h80, 3'd1, 1'b0);
    // Second redirect while flushing reloads; writeback still retires in FLUSH.
    redirect_i = 1'b1;        step("t4_r1",  1'b0, 1'b0, 2'b11, 32'h80, 3'd1, 1'b0);
    redirect_i = 1'b1;        step("t4_r2",  1'b0, 1'b0, 2'b11, 32'h80, 3'd1, 1'b0);
    set_wb(5'd7);             step("t4_g1",  1'b0, 1'b0, 2'b01, 32'h80, 3'd1, 1'b0);
                              step("t4_g2",  1'b0, 1'b0, 2'b01, 32'h0,  3'd0, 1'b0);
                              step("t4_end", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);

    // Writeback to a non-pending register.
    set_wb(5'd9);             step("t5_wb9", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
                              step("t5_err", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b1);
                              step("t5_end", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);

    // Reset in the middle of FLUSH with three loads outstanding.
    set_ld(5'd1);             step("t6_l1",  1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
    set_ld(5'd2);             step("t6_l2",  1'b1, 1'b0, 2'b00, 32'h2,  3'd1, 1'b0);
    set_ld(5'd3);             step("t6_l3",  1'b1, 1'b0, 2'b00, 32'h6,  3'd2, 1'b0);
    redirect_i = 1'b1;        step("t6_r",   1'b0, 1'b0, 2'b11, 32'hE,  3'd3, 1'b0);
    rst_i = 1'b1; set_ld(5'd9); redirect_i = 1'b1;
                              step("t6_rst", 1'b0, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
    rst_i = 1'b0;
    set_ld(5'd9);             step("t6_run", 1'b1, 1'b0, 2'b00, 32'h0,  3'd0, 1'b0);
                              step("t6_p9",  1'b0, 1'b0, 2'b00, 32'h200, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
